// File: rtl/id_pkg.sv
// id_pkg: shared decode definitions for the instruction-decode stage.
//   - MIPS opcode / funct constants for the supported subset
//   - control-word bit layout and field enums
//   - pack_ctrl helper that builds a control word from its fields
//
// Control word layout (16 bits):
//   [15]    RegWrite
//   [14]    MemRead
//   [13]    MemWrite
//   [12:11] MemToReg  (memtoreg_e)
//   [10:9]  RegDst    (regdst_e)
//   [8]     ALUSrc    (1 = immediate operand)
//   [7:4]   ALUOp     (alu_op_e)
//   [3:1]   Branch    (branch_e, resolved in EX)
//   [0]     ExtOp     (1 = immediate was sign-extended)
package id_pkg;

  localparam int CTRL_BITS = 16;

  localparam int C_REGWRITE = 15;
  localparam int C_MEMREAD  = 14;
  localparam int C_MEMWRITE = 13;
  localparam int C_M2R_LO   = 11;
  localparam int C_RDST_LO  = 9;
  localparam int C_ALUSRC   = 8;
  localparam int C_ALUOP_LO = 4;
  localparam int C_BR_LO    = 1;
  localparam int C_EXTOP    = 0;

  localparam logic [CTRL_BITS-1:0] CTRL_BUBBLE = '0;

  // Opcodes
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    RDST_RT = 2'd0,
    RDST_RD = 2'd1,
    RDST_RA = 2'd2
  } regdst_e;

  typedef enum logic [1:0] {
    M2R_ALU = 2'd0,
    M2R_MEM = 2'd1,
    M2R_PC  = 2'd2
  } memtoreg_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_ADDU = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SUBU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_SLL  = 4'd10,
    ALU_SRL  = 4'd11,
    ALU_SRA  = 4'd12,
    ALU_LUI  = 4'd13
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BLEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLTZ = 3'd5
  } branch_e;

  // Concatenation order matches the bit positions above.
  function automatic logic [CTRL_BITS-1:0] pack_ctrl(
    input logic      rw,
    input logic      mr,
    input logic      mw,
    input memtoreg_e m2r,
    input regdst_e   rdst,
    input logic      alusrc,
    input alu_op_e   aluop,
    input branch_e   br,
    input logic      ext
  );
    return {rw, mr, mw, m2r, rdst, alusrc, aluop, br, ext};
  endfunction

endpackage

// File: rtl/id_decoder.sv
// id_decoder: purely combinational instruction decoder.
// Ports:
//   opcode    in  6   Instruction[31:26]
//   rt        in  5   Instruction[20:16] (selects REGIMM sub-op)
//   funct     in  6   Instruction[5:0]
//   ctrl      out 16  packed control word (layout in id_pkg)
//   uses_rt   out 1   instruction reads rt as a source operand
//   undefined out 1   opcode/funct not in the supported subset
//   is_j      out 1   j or jal
//   is_jr     out 1   jr or jalr
module id_decoder
  import id_pkg::*;
(
  input  logic [5:0]           opcode,
  input  logic [4:0]           rt,
  input  logic [5:0]           funct,
  output logic [CTRL_BITS-1:0] ctrl,
  output logic                 uses_rt,
  output logic                 undefined,
  output logic                 is_j,
  output logic                 is_jr
);

  // ALU op and validity for ordinary R-type arithmetic.
  alu_op_e r_op;
  logic    r_ok;

  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    unique case (funct)
      FN_SLL:  r_op = ALU_SLL;
      FN_SRL:  r_op = ALU_SRL;
      FN_SRA:  r_op = ALU_SRA;
      FN_ADD:  r_op = ALU_ADD;
      FN_ADDU: r_op = ALU_ADDU;
      FN_SUB:  r_op = ALU_SUB;
      FN_SUBU: r_op = ALU_SUBU;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_XOR:  r_op = ALU_XOR;
      FN_NOR:  r_op = ALU_NOR;
      FN_SLT:  r_op = ALU_SLT;
      FN_SLTU: r_op = ALU_SLTU;
      default: r_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    uses_rt   = 1'b0;
    undefined = 1'b0;
    is_j      = 1'b0;
    is_jr     = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          is_jr = 1'b1;
        end else if (funct == FN_JALR) begin
          is_jr = 1'b1;
          ctrl  = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_PC, RDST_RD, 1'b0, ALU_ADD, BR_NONE, 1'b0);
        end else if (r_ok) begin
          uses_rt = 1'b1;
          ctrl    = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_ALU, RDST_RD, 1'b0, r_op, BR_NONE, 1'b0);
        end else begin
          undefined = 1'b1;
        end
      end
      OP_REGIMM: begin
        // Only bltz (rt == 0) is supported from the REGIMM group.
        if (rt == 5'd0)
          ctrl = pack_ctrl(1'b0, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b0, ALU_SUB, BR_BLTZ, 1'b1);
        else
          undefined = 1'b1;
      end
      OP_J: is_j = 1'b1;
      OP_JAL: begin
        is_j = 1'b1;
        ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_PC, RDST_RA, 1'b0, ALU_ADD, BR_NONE, 1'b0);
      end
      OP_BEQ: begin
        uses_rt = 1'b1;
        ctrl    = pack_ctrl(1'b0, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b0, ALU_SUB, BR_BEQ, 1'b1);
      end
      OP_BNE: begin
        uses_rt = 1'b1;
        ctrl    = pack_ctrl(1'b0, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b0, ALU_SUB, BR_BNE, 1'b1);
      end
      OP_BLEZ:  ctrl = pack_ctrl(1'b0, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b0, ALU_SUB, BR_BLEZ, 1'b1);
      OP_BGTZ:  ctrl = pack_ctrl(1'b0, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b0, ALU_SUB, BR_BGTZ, 1'b1);
      OP_ADDI:  ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b1, ALU_ADD, BR_NONE, 1'b1);
      OP_ADDIU: ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b1, ALU_ADDU, BR_NONE, 1'b1);
      OP_SLTI:  ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b1, ALU_SLT, BR_NONE, 1'b1);
      OP_SLTIU: ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b1, ALU_SLTU, BR_NONE, 1'b1);
      OP_ANDI:  ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b1, ALU_AND, BR_NONE, 1'b0);
      OP_LUI:   ctrl = pack_ctrl(1'b1, 1'b0, 1'b0, M2R_ALU, RDST_RT, 1'b1, ALU_LUI, BR_NONE, 1'b0);
      OP_LW:    ctrl = pack_ctrl(1'b1, 1'b1, 1'b0, M2R_MEM, RDST_RT, 1'b1, ALU_ADD, BR_NONE, 1'b1);
      OP_SW: begin
        uses_rt = 1'b1;
        ctrl    = pack_ctrl(1'b0, 1'b0, 1'b1, M2R_ALU, RDST_RT, 1'b1, ALU_ADD, BR_NONE, 1'b1);
      end
      default: undefined = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction-decode pipeline stage.
// Decodes the IF_ID word, reads the register file, resolves j/jal/jr/jalr,
// detects load-use and jr hazards and registers the ID_EX bundle.
// Ports:
//   clk, reset            clock; synchronous active-high reset of ID_EX
//   IF_ID[63:0]           {PC_Plus4, Instruction}
//   rs_addr, rt_addr      regfile read addresses
//   rs_data, rt_data      regfile read data (write-through)
//   EX_MemRead, EX_RegWrite, EX_dst  hazard info from the EX stage
//   ID_Flush              kill the instruction currently in ID
//   IF_Pause, IF_Flush    combinational stall / nop-insert requests to fetch
//   PCSrc[2:0]            {JR, J, 0} redirect select
//   jump_address, jr_address  redirect targets
//   exception             undefined instruction accepted this cycle
//   ID_EX_*               registered bundle for execute
//
// Pipeline control: there is no valid/ready pair. Every cycle ID either
// passes its instruction to ID_EX or inserts a bubble. IF_Pause=1 means
// fetch must hold PC and IF_ID so the same instruction is seen again;
// IF_Flush=1 means the next IF_ID word must be a nop. Priority of the
// bubble sources: reset > ID_Flush > hazard stall > undefined instruction.
module id_stage
  import id_pkg::*;
#(
  parameter int          CTRL_W    = 16,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [63:0]       IF_ID,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  input  logic [31:0]       rs_data,
  input  logic [31:0]       rt_data,
  input  logic              EX_MemRead,
  input  logic              EX_RegWrite,
  input  logic [4:0]        EX_dst,
  input  logic              ID_Flush,
  output logic              IF_Pause,
  output logic              IF_Flush,
  output logic [2:0]        PCSrc,
  output logic [31:0]       jump_address,
  output logic [31:0]       jr_address,
  output logic              exception,
  output logic [31:0]       ID_EX_PC_Plus4,
  output logic [31:0]       ID_EX_rs_data,
  output logic [31:0]       ID_EX_rt_data,
  output logic [31:0]       ID_EX_imm,
  output logic [4:0]        ID_EX_rs,
  output logic [4:0]        ID_EX_rt,
  output logic [4:0]        ID_EX_rd,
  output logic [4:0]        ID_EX_shamt,
  output logic [CTRL_W-1:0] ID_EX_ctrl
);

  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [31:0] imm_ext;

  assign pc_plus4 = IF_ID[63:32];
  assign instr    = IF_ID[31:0];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign imm16    = instr[15:0];

  assign rs_addr      = rs;
  assign rt_addr      = rt;
  assign jump_address = {pc_plus4[31:28], instr[25:0], 2'b00};
  assign jr_address   = rs_data;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              uses_rt, undefined, is_j, is_jr;

  id_decoder u_decoder (
    .opcode    (instr[31:26]),
    .rt        (rt),
    .funct     (instr[5:0]),
    .ctrl      (dec_ctrl),
    .uses_rt   (uses_rt),
    .undefined (undefined),
    .is_j      (is_j),
    .is_jr     (is_jr)
  );

  always_comb begin
    imm_ext = {{16{imm16[15]}}, imm16};
    if (instr[31:26] == OP_ANDI)
      imm_ext = {16'h0000, imm16};
    else if (instr[31:26] == OP_LUI)
      imm_ext = {imm16, 16'h0000};
  end

  // Load-use compares rs unconditionally; rt only when it is a real source.
  logic load_use, jr_hazard, stall;
  assign load_use  = EX_MemRead && (EX_dst != 5'd0) &&
                     ((EX_dst == rs) || ((EX_dst == rt) && uses_rt));
  // jr/jalr read rs in ID, so any in-flight writer of rs must drain first.
  assign jr_hazard = is_jr && EX_RegWrite && (EX_dst != 5'd0) && (EX_dst == rs);
  assign stall     = load_use || jr_hazard;

  // take = 1 loads the decoded instruction into ID_EX, else a bubble.
  logic take;

  always_comb begin
    IF_Pause  = 1'b0;
    IF_Flush  = 1'b0;
    PCSrc     = 3'b000;
    exception = 1'b0;
    take      = 1'b0;
    if (ID_Flush) begin
      take = 1'b0;
    end else if (stall) begin
      IF_Pause = 1'b1;
    end else if (undefined) begin
      exception = 1'b1;
    end else begin
      take = 1'b1;
      if (is_j) begin
        PCSrc    = 3'b010;
        IF_Flush = 1'b1;
      end else if (is_jr) begin
        PCSrc    = 3'b100;
        IF_Flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !take) begin
      ID_EX_PC_Plus4 <= RESET_VEC;
      ID_EX_rs_data  <= '0;
      ID_EX_rt_data  <= '0;
      ID_EX_imm      <= '0;
      ID_EX_rs       <= '0;
      ID_EX_rt       <= '0;
      ID_EX_rd       <= '0;
      ID_EX_shamt    <= '0;
      ID_EX_ctrl     <= '0;
    end else begin
      ID_EX_PC_Plus4 <= pc_plus4;
      ID_EX_rs_data  <= rs_data;
      ID_EX_rt_data  <= rt_data;
      ID_EX_imm      <= imm_ext;
      ID_EX_rs       <= rs;
      ID_EX_rt       <= rt;
      ID_EX_rd       <= rd;
      ID_EX_shamt    <= shamt;
      ID_EX_ctrl     <= dec_ctrl;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Instruction-decode stage, directly downstream of the fetch stage. Consumes the 64-bit IF_ID register {PC_Plus4, Instruction}. Decodes the MIPS subset, reads the register file and resolves j/jal/jr/jalr in ID. Detects load-use and jr hazards, drives stall/flush/redirect back to fetch, and registers the ID_EX pipeline bundle for execute.

Parameters:
CTRL_W, 16, width of packed control word (layout in package)
RESET_VEC, 32'h0000_0000, ID_EX_PC_Plus4 value after reset or bubble

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all ID_EX state
IF_ID  in  64  {PC_Plus4[63:32], Instruction[31:0]}; 32'd0 instruction = nop
rs_addr  out  5  regfile read address = Instruction[25:21]
rt_addr  out  5  regfile read address = Instruction[20:16]
rs_data  in  32  regfile read data (write-through for same-cycle WB write)
rt_data  in  32  regfile read data (write-through)
EX_MemRead  in  1  instruction in EX is a load
EX_RegWrite  in  1  instruction in EX writes a register
EX_dst  in  5  destination register of instruction in EX
ID_Flush  in  1  EX branch taken or exception/interrupt: kill ID contents
IF_Pause  out  1  comb: hold PC and IF_ID
IF_Flush  out  1  comb: replace next IF_ID instruction with nop
PCSrc  out  3  comb {JR, J, 0}; branch bit OR-ed in by EX at top level
jump_address  out  32  {PC_Plus4[31:28], Instruction[25:0], 2'b00}
jr_address  out  32  rs_data
exception  out  1  comb: undefined opcode/funct decoded, not stalled/flushed
ID_EX_PC_Plus4  out  32  registered
ID_EX_rs_data, ID_EX_rt_data  out  32 each  registered operands
ID_EX_imm  out  32  registered extended immediate
ID_EX_rs, ID_EX_rt, ID_EX_rd, ID_EX_shamt  out  5 each  registered fields
ID_EX_ctrl  out  CTRL_W  registered control word

Behaviour:
- Supported: R-type add/addu/sub/subu/and/or/xor/nor/slt/sltu/sll/srl/sra/jr/jalr; lw, sw, lui, addi, addiu, andi, slti, sltiu, beq, bne, blez, bgtz, bltz, j, jal.
- Immediate: zero-extend for andi; lui places imm in [31:16]; all others sign-extend.
- jal: RegDst=RA (writes $31), MemToReg=PC (writes PC_Plus4). jalr: writes rd with PC_Plus4.
- Branches are not resolved here. Only the branch type goes into ctrl.
- Load-use stall: EX_MemRead && EX_dst!=0 && (EX_dst==rs || (EX_dst==rt && instr reads rt)). Effects: IF_Pause=1, IF_Flush=0, PCSrc=000, exception=0, next ID_EX = bubble.
- jr/jalr stall: EX_RegWrite && EX_dst!=0 && EX_dst==rs. Same effects as load-use, held until the hazard clears.
- Jump, no stall, no ID_Flush: j/jal give PCSrc=010; jr/jalr give PCSrc=100. Both assert IF_Flush=1, and the instruction itself is passed to ID_EX.
- Undefined opcode/funct: exception=1 for that cycle, ID_EX gets bubble.
- ID_Flush=1 has highest priority: IF_Pause=0, IF_Flush=0, PCSrc=000, exception=0, next ID_EX = bubble.
- Bubble: ctrl=0, all fields 0, PC_Plus4=RESET_VEC.
- Priority order: reset > ID_Flush > stall > exception > normal/jump.
- Reset: all ID_EX outputs equal bubble after the first edge with reset=1.
- Combinational outputs follow IF_ID, which the upstream stage zeroes on its reset, so they decode a nop.
- Latency: one cycle IF_ID -> ID_EX. Redirect/stall signals are same-cycle combinational.

Decomposition:
- Package id_pkg: opcode and funct constants; ctrl bit positions (RegWrite, MemRead, MemWrite, MemToReg[1:0], RegDst[1:0], ALUSrc, ALUOp[3:0], Branch[2:0], ExtOp); RegDst/MemToReg enums; CTRL_BUBBLE constant.
- Sub-module: id_decoder. Purely combinational instruction -> ctrl word, uses_rt, undefined flag. The hazard/priority logic and the ID_EX register stay in id_stage.

Test Plan:
- Reset held 2 cycles with IF_ID={32'h8000_0004, 32'h2008_0005} (addi $8,$0,5) -> all ID_EX zero. After release, next edge gives ID_EX_imm=5, rt=8, RegWrite=1, ALUSrc=1.
- IF_ID instr 32'h0800_0010 (j), PC_Plus4=32'h8000_0104 -> jump_address=32'h8000_0040, PCSrc=010, IF_Flush=1, IF_Pause=0.
- EX_MemRead=1, EX_dst=9 with ID instr add $10,$9,$11 -> IF_Pause=1, next ID_EX_ctrl=0. Drop EX_MemRead -> decode proceeds the following cycle.
- jr $31 with EX_RegWrite=1, EX_dst=31 -> PCSrc=000, IF_Pause=1. Next cycle with no hazard and rs_data=32'h0000_0400 -> PCSrc=100, jr_address=32'h0000_0400, IF_Flush=1.
- ID_Flush=1 with simultaneous load-use hazard and j in ID -> IF_Pause=0, PCSrc=000, IF_Flush=0, ID_EX bubble.
- Undefined opcode 6'h3F -> exception=1 for one cycle, ID_EX bubble. Same instruction during a stall -> exception=0.
